// File: rtl/mem_arbiter_if.sv
// Bus bundle between two clients, the arbiter and a dual-port memory.
interface mem_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 6
);
    logic             stall;

    logic             c0_valid;
    logic             c0_ready;
    logic             c0_we;
    logic [AW-1:0]    c0_addr;
    logic [WIDTH-1:0] c0_wdata;
    logic             c0_rvalid;
    logic [WIDTH-1:0] c0_rdata;

    logic             c1_valid;
    logic             c1_ready;
    logic             c1_we;
    logic [AW-1:0]    c1_addr;
    logic [WIDTH-1:0] c1_wdata;
    logic             c1_rvalid;
    logic [WIDTH-1:0] c1_rdata;

    logic [WIDTH-1:0] mem_data;
    logic [AW-1:0]    mem_wraddress;
    logic             mem_wren;
    logic [AW-1:0]    mem_rdaddress;
    logic             mem_rden;
    logic [WIDTH-1:0] mem_q;

    logic             busy;

    // Arbiter view: takes client requests and memory read data.
    modport slave (
        input  stall,
        input  c0_valid, c0_we, c0_addr, c0_wdata,
        output c0_ready, c0_rvalid, c0_rdata,
        input  c1_valid, c1_we, c1_addr, c1_wdata,
        output c1_ready, c1_rvalid, c1_rdata,
        output mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_rden,
        input  mem_q,
        output busy
    );

    // Client / environment view: issues requests and models the memory.
    modport master (
        output stall,
        output c0_valid, c0_we, c0_addr, c0_wdata,
        input  c0_ready, c0_rvalid, c0_rdata,
        output c1_valid, c1_we, c1_addr, c1_wdata,
        input  c1_ready, c1_rvalid, c1_rdata,
        input  mem_data, mem_wraddress, mem_wren, mem_rdaddress, mem_rden,
        output mem_q,
        input  busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-client arbiter sharing one dual-port memory with a
// 1-cycle registered read. One accept per cycle; reads return two cycles
// after the accept edge on the requesting client's rvalid/rdata.
module mem_arbiter #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 64,
    parameter int FIXED_PRIO = 0
) (
    input  logic         clock,
    input  logic         reset,
    mem_arbiter_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic             gnt0, gnt1;
    logic             acc0, acc1, acc_any;
    logic             acc_we;
    logic [AW-1:0]    acc_addr;
    logic [WIDTH-1:0] acc_wdata;

    // Round-robin pointer: 0 favours client 0, 1 favours client 1.
    logic             rr_ptr;

    logic             wren_q;
    logic [AW-1:0]    wraddr_q;
    logic [AW-1:0]    rdaddr_q;
    logic [WIDTH-1:0] data_q;

    // Read tag pipeline: valid bit and client id per stage.
    logic             rd_vld_p0, rd_id_p0;
    logic             rd_vld_p1, rd_id_p1;

    // Grant: at most one client, never while stalled; ties follow priority mode.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!bus.stall) begin
            if (bus.c0_valid && bus.c1_valid) begin
                if ((FIXED_PRIO != 0) || !rr_ptr) gnt0 = 1'b1;
                else                              gnt1 = 1'b1;
            end else begin
                gnt0 = bus.c0_valid;
                gnt1 = bus.c1_valid;
            end
        end
    end

    assign bus.c0_ready = gnt0;
    assign bus.c1_ready = gnt1;

    assign acc0      = bus.c0_valid & gnt0;
    assign acc1      = bus.c1_valid & gnt1;
    assign acc_any   = acc0 | acc1;
    assign acc_we    = acc1 ? bus.c1_we    : bus.c0_we;
    assign acc_addr  = acc1 ? bus.c1_addr  : bus.c0_addr;
    assign acc_wdata = acc1 ? bus.c1_wdata : bus.c0_wdata;

    // Pointer moves to the other client after every accept.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)     rr_ptr <= 1'b0;
        else if (acc0) rr_ptr <= 1'b1;
        else if (acc1) rr_ptr <= 1'b0;
    end

    // Stage p0: register the accepted operation onto the memory ports.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wren_q    <= 1'b0;
            rd_vld_p0 <= 1'b0;
            rd_id_p0  <= 1'b0;
            wraddr_q  <= '0;
            rdaddr_q  <= '0;
            data_q    <= '0;
        end else begin
            wren_q    <= acc_any & acc_we;
            rd_vld_p0 <= acc_any & ~acc_we;
            if (acc_any) rd_id_p0 <= acc1;
            if (acc_any && acc_we) begin
                wraddr_q <= acc_addr;
                data_q   <= acc_wdata;
            end
            if (acc_any && !acc_we) rdaddr_q <= acc_addr;
        end
    end

    // Stage p1: memory has sampled the read address; q is valid this cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_vld_p1 <= 1'b0;
            rd_id_p1  <= 1'b0;
        end else begin
            rd_vld_p1 <= rd_vld_p0;
            rd_id_p1  <= rd_id_p0;
        end
    end

    assign bus.mem_wren      = wren_q;
    assign bus.mem_wraddress = wraddr_q;
    assign bus.mem_data      = data_q;
    assign bus.mem_rden      = rd_vld_p0;
    assign bus.mem_rdaddress = rdaddr_q;

    assign bus.c0_rvalid = rd_vld_p1 & ~rd_id_p1;
    assign bus.c1_rvalid = rd_vld_p1 &  rd_id_p1;
    assign bus.c0_rdata  = bus.mem_q;
    assign bus.c1_rdata  = bus.mem_q;

    assign bus.busy = rd_vld_p0 | rd_vld_p1;
endmodule
